spi_master: RTL
===============

# spi_master

Single-clock SPI master that drives the SS_n/MOSI/MISO link of the SPI slave from the host side. A host issues one 10-bit command word per frame; the master frames it with SS_n, shifts it out MSB-first on MOSI one bit per clk, and for read-data commands (cmd[9:8] = 2'b11) captures the 8-bit reply from MISO. It sits between the system controller and the slave, and serves as the stimulus and reference end in slave-level environments.

## Interface
- ADDR_SIZE, 8, slave address/data width; command word is ADDR_SIZE+2 bits
- RD_WAIT, 2, SS_n-low turnaround cycles between the last MOSI bit and the first MISO sample (1..15)
- Reset is synchronous and active-high.

- clk  input  1  system clock; all activity on rising edge, shared with slave
- rst  input  1  synchronous active-high reset
- cmd_valid  input  1  host command request
- cmd_data  input  ADDR_SIZE+2  command word; [9:8] = opcode, [7:0] = address/data
- cmd_ready  output  1  master idle, command accepted when cmd_valid && cmd_ready
- rsp_valid  output  1  one-cycle pulse, rsp_data valid
- rsp_data  output  ADDR_SIZE  byte captured from MISO, held until next read completes
- busy  output  1  frame in progress (state != IDLE)
- SS_n  output  1  slave select, active-low
- MOSI  output  1  serial data to slave
- MISO  input  1  serial data from slave

## Operation
- States: IDLE, START, SHIFT, WAIT, RECV, END.
- IDLE: SS_n=1, MOSI=0, cmd_ready=1. On accept, latch cmd_data into shift register, go START.
- START (1 cycle): SS_n=0, MOSI=cmd[9] (slave command-check cycle).
- SHIFT (10 cycles): MOSI = cmd[9], cmd[8], ..., cmd[0]; 4-bit bit counter 9 down to 0. At count 0: opcode 2'b11 -> WAIT, else -> END.
- WAIT (RD_WAIT cycles): SS_n=0, MOSI=0.
- RECV (ADDR_SIZE cycles): SS_n=0, MOSI=0; sample MISO each rising edge into rx shift register, MSB first.
- END (1 cycle): SS_n=1, cmd_ready=0; after a read, rsp_data updated and rsp_valid=1 in this cycle. Then IDLE.
- Opcodes 00, 01 and 10 are write-type frames with no response; the master does not track slave read-address state.
- cmd_valid while cmd_ready=0 is ignored, not queued; cmd_data is sampled only on the accept cycle.

## Timing
- Reset values: SS_n=1, MOSI=0, cmd_ready=1 (IDLE), busy=0, rsp_valid=0, rsp_data=0, counters 0.
- Accept at edge T -> START at T+1, SHIFT T+2..T+11 (bit9 at T+2, bit0 at T+11).
- Non-read frame: END at T+12; SS_n low for exactly 11 cycles; next accept possible at T+13.
- Read frame: WAIT T+12..T+11+RD_WAIT; RECV T+12+RD_WAIT..T+19+RD_WAIT (MISO bit7 sampled at the first RECV edge); END with rsp_valid at T+20+RD_WAIT.
- Minimum SS_n-high gap between frames: 2 cycles (END + IDLE accept cycle).
- rst asserted mid-frame: next edge forces IDLE, SS_n=1, MOSI=0, no rsp_valid; rsp_data is cleared to 0.
- rst and cmd_valid in the same cycle: reset wins, command dropped.

## Test plan
- Reset: hold rst 3 cycles with cmd_valid=1 -> SS_n=1, MOSI=0, cmd_ready=1, rsp_valid=0, rsp_data=0x00, no frame started.
- Write frame cmd=10'b00_1010_0101 -> SS_n low 11 cycles, MOSI at T+2..T+11 = 0,0,1,0,1,0,0,1,0,1; no rsp_valid; cmd_ready high again at T+13.
- Read-data cmd=10'b11_0000_0000, RD_WAIT=2, MISO drives 0xC3 MSB first from T+14 -> rsp_valid single pulse at T+22 with rsp_data=0xC3; SS_n rises at T+22.
- Back-to-back: cmd_valid held high with 01 then 11 commands -> second accept exactly 2 cycles after first SS_n rise; second command not accepted while busy.
- Mid-frame reset: rst at T+6 of a read frame -> SS_n=1 at T+7, no rsp_valid, next command runs a clean full frame.
- Slave loopback: connect to SPI slave, write address 0x20 (00), write data 0x5A (01), read address 0x20 (10), read data (11) -> rsp_data=0x5A, matching the slave's rx_data/rx_valid stream.

Source files
------------

// File: rtl/spi_master.sv
// spi_master: frames a 10-bit command on SS_n/MOSI and captures the 8-bit read reply from MISO
module spi_master #(
    parameter int ADDR_SIZE = 8,
    parameter int RD_WAIT   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    input  logic [ADDR_SIZE+1:0] cmd_data,
    output logic                 cmd_ready,
    output logic                 rsp_valid,
    output logic [ADDR_SIZE-1:0] rsp_data,
    output logic                 busy,
    output logic                 SS_n,
    output logic                 MOSI,
    input  logic                 MISO
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] SHIFT = 3'd2;
    localparam logic [2:0] WAIT  = 3'd3;
    localparam logic [2:0] RECV  = 3'd4;
    localparam logic [2:0] END   = 3'd5;

    logic [2:0]           state;
    logic [3:0]           cnt;
    logic                 rd;
    logic [ADDR_SIZE+1:0] sr;
    logic [ADDR_SIZE-2:0] rx;

    // frame sequencer: shift the command out MSB first, then collect the reply on reads
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rd        <= 1'b0;
            sr        <= '0;
            rx        <= '0;
            rsp_data  <= '0;
            rsp_valid <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: if (cmd_valid) begin
                    sr    <= cmd_data;
                    rd    <= &cmd_data[ADDR_SIZE+1:ADDR_SIZE];
                    state <= START;
                end
                START: begin
                    cnt   <= 4'(ADDR_SIZE + 1);
                    state <= SHIFT;
                end
                SHIFT: begin
                    sr  <= sr << 1;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state <= rd ? WAIT : END;
                        cnt   <= 4'(RD_WAIT - 1);
                    end
                end
                WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state <= RECV;
                        cnt   <= 4'(ADDR_SIZE - 1);
                    end
                end
                RECV: begin
                    rx  <= {rx[ADDR_SIZE-3:0], MISO};
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        rsp_data  <= {rx, MISO};
                        rsp_valid <= 1'b1;
                        state     <= END;
                    end
                end
                END:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // link outputs decoded from the current state; START already presents the first bit
    always_comb begin
        cmd_ready = state == IDLE;
        busy      = state != IDLE;
        SS_n      = state == IDLE || state == END;
        MOSI      = (state == START || state == SHIFT) ? sr[ADDR_SIZE+1] : 1'b0;
    end
endmodule
